// File: rtl/switch_port_gen2_if.sv
// Bundle of link ingress/egress, arbiter and fabric signals for one switch port.
// slave is the port's view; master is the environment driving it.
interface switch_port_gen2_if #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned PKT_W = 2 * N_PORTS + DATA_W;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    logic               valid_in;
    logic               ready_in;
    logic [N_PORTS-1:0] source_in;
    logic [N_PORTS-1:0] target_in;
    logic [DATA_W-1:0]  data_in;

    logic               valid_out;
    logic               ready_out;
    logic [N_PORTS-1:0] source_out;
    logic [N_PORTS-1:0] target_out;
    logic [DATA_W-1:0]  data_out;
    logic               tx_done;

    logic               request;
    logic [N_PORTS-1:0] request_target;
    logic [PKT_W-1:0]   request_data;
    logic               grant;

    logic               internal_valid;
    logic               internal_ready;
    logic [PKT_W-1:0]   internal_data;

    logic [AW:0]        fifo_count;
    logic [15:0]        drop_count;

    modport master (
        output valid_in, source_in, target_in, data_in, ready_out, grant,
               internal_valid, internal_data,
        input  ready_in, valid_out, source_out, target_out, data_out, tx_done,
               request, request_target, request_data, internal_ready,
               fifo_count, drop_count
    );

    modport slave (
        input  valid_in, source_in, target_in, data_in, ready_out, grant,
               internal_valid, internal_data,
        output ready_in, valid_out, source_out, target_out, data_out, tx_done,
               request, request_target, request_data, internal_ready,
               fifo_count, drop_count
    );
endinterface

// File: rtl/switch_port_gen2.sv
// Switch port: legality-checked ingress FIFO presented to the arbiter, plus a
// valid/ready egress register fed from the fabric.
module switch_port_gen2 #(
    parameter int unsigned N_PORTS      = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PORT_ID      = 0,
    parameter bit          BACKPRESSURE = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    switch_port_gen2_if.slave port_if
);
    localparam int unsigned PKT_W = 2 * N_PORTS + DATA_W;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]        DepthCnt = (AW + 1)'(FIFO_DEPTH);
    localparam logic [N_PORTS-1:0] OwnBit   = N_PORTS'(1) << PORT_ID;

    logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [15:0]      r_drop_cnt;
    logic             r_valid_out;
    logic             r_tx_done;
    logic [PKT_W-1:0] r_out_pkt;

    logic             w_full;
    logic             w_empty;
    logic             w_src_onehot;
    logic             w_legal;
    logic             w_ready_in;
    logic             w_accept;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic             w_internal_ready;
    logic [PKT_W-1:0] w_head;

    assign w_full  = (r_count == DepthCnt);
    assign w_empty = (r_count == '0);

    assign w_src_onehot = (port_if.source_in != '0) &&
                          ((port_if.source_in & (port_if.source_in - N_PORTS'(1))) == '0);
    assign w_legal = w_src_onehot && (port_if.source_in == OwnBit) &&
                     (port_if.target_in != '0) &&
                     ((port_if.target_in & port_if.source_in) == '0);

    assign w_ready_in = BACKPRESSURE ? !w_full : 1'b1;
    assign w_accept   = port_if.valid_in && w_ready_in;
    // A full FIFO drops even if grant frees a slot this cycle: no bypass path.
    assign w_push     = w_accept && w_legal && !w_full;
    assign w_drop     = w_accept && !w_push;
    assign w_pop      = port_if.grant && !w_empty;

    assign w_internal_ready = !r_valid_out || port_if.ready_out;
    assign w_head           = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_mem[r_wr_ptr] <= {port_if.source_in, port_if.target_in, port_if.data_in};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drop_cnt  <= '0;
            r_valid_out <= 1'b0;
            r_tx_done   <= 1'b0;
            r_out_pkt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            r_tx_done <= r_valid_out && port_if.ready_out;
            if (port_if.internal_valid && w_internal_ready) begin
                r_valid_out <= 1'b1;
                r_out_pkt   <= port_if.internal_data;
            end else if (port_if.ready_out) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign port_if.ready_in       = w_ready_in;
    assign port_if.request        = !w_empty;
    assign port_if.request_data   = w_head;
    assign port_if.request_target = w_head[DATA_W +: N_PORTS];
    assign port_if.internal_ready = w_internal_ready;
    assign port_if.valid_out      = r_valid_out;
    assign port_if.source_out     = r_out_pkt[DATA_W + N_PORTS +: N_PORTS];
    assign port_if.target_out     = r_out_pkt[DATA_W +: N_PORTS];
    assign port_if.data_out       = r_out_pkt[DATA_W-1:0];
    assign port_if.tx_done        = r_tx_done;
    assign port_if.fifo_count     = r_count;
    assign port_if.drop_count     = r_drop_cnt;
endmodule

// File: tb/tb_switch_port_gen2.sv
// Drives a backpressure port (index 0) and a drop-mode port (index 1) with shared
// stimulus, checking both against a queue-based model every cycle.
module tb_switch_port_gen2;
    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned D     = 4;
    localparam int unsigned PKT_W = 2 * N + DW;
    localparam int unsigned AW    = $clog2(D);
    localparam logic [N-1:0] OWN  = 4'b0001;

    typedef logic [PKT_W-1:0] pkt_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic [N-1:0] src = '0;
    logic [N-1:0] tgt = '0;
    logic [DW-1:0] data = '0;
    logic grant = 1'b0;
    logic iv = 1'b0;
    logic [PKT_W-1:0] idata = '0;
    logic ready_out = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    switch_port_gen2_if #(.N_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(D)) if_bp ();
    switch_port_gen2_if #(.N_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(D)) if_dr ();

    switch_port_gen2 #(.N_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(D), .PORT_ID(0),
                       .BACKPRESSURE(1'b1)) u_bp (
        .i_clk(clk), .i_rst_n(rst_n), .port_if(if_bp)
    );
    switch_port_gen2 #(.N_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(D), .PORT_ID(0),
                       .BACKPRESSURE(1'b0)) u_dr (
        .i_clk(clk), .i_rst_n(rst_n), .port_if(if_dr)
    );

    assign if_bp.valid_in = valid_in;       assign if_dr.valid_in = valid_in;
    assign if_bp.source_in = src;           assign if_dr.source_in = src;
    assign if_bp.target_in = tgt;           assign if_dr.target_in = tgt;
    assign if_bp.data_in = data;            assign if_dr.data_in = data;
    assign if_bp.grant = grant;             assign if_dr.grant = grant;
    assign if_bp.internal_valid = iv;       assign if_dr.internal_valid = iv;
    assign if_bp.internal_data = idata;     assign if_dr.internal_data = idata;
    assign if_bp.ready_out = ready_out;     assign if_dr.ready_out = ready_out;

    logic o_ready_in [2];
    logic o_request [2];
    logic [N-1:0] o_req_tgt [2];
    logic [PKT_W-1:0] o_req_data [2];
    logic o_iready [2];
    logic o_valid_out [2];
    logic [PKT_W-1:0] o_out_pkt [2];
    logic o_tx_done [2];
    logic [AW:0] o_count [2];
    logic [15:0] o_drop [2];

    assign o_ready_in[0] = if_bp.ready_in;         assign o_ready_in[1] = if_dr.ready_in;
    assign o_request[0] = if_bp.request;           assign o_request[1] = if_dr.request;
    assign o_req_tgt[0] = if_bp.request_target;    assign o_req_tgt[1] = if_dr.request_target;
    assign o_req_data[0] = if_bp.request_data;     assign o_req_data[1] = if_dr.request_data;
    assign o_iready[0] = if_bp.internal_ready;     assign o_iready[1] = if_dr.internal_ready;
    assign o_valid_out[0] = if_bp.valid_out;       assign o_valid_out[1] = if_dr.valid_out;
    assign o_out_pkt[0] = {if_bp.source_out, if_bp.target_out, if_bp.data_out};
    assign o_out_pkt[1] = {if_dr.source_out, if_dr.target_out, if_dr.data_out};
    assign o_tx_done[0] = if_bp.tx_done;           assign o_tx_done[1] = if_dr.tx_done;
    assign o_count[0] = if_bp.fifo_count;          assign o_count[1] = if_dr.fifo_count;
    assign o_drop[0] = if_bp.drop_count;           assign o_drop[1] = if_dr.drop_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: per port a packet queue, drop tally, egress slot and tx_done flag.
    pkt_q_t m_q [2];
    int unsigned m_drop [2];
    bit m_ov [2];
    logic [PKT_W-1:0] m_pkt [2];
    bit m_tx [2];
    bit model_ok = 1'b0;

    function automatic bit legal(input logic [N-1:0] s, input logic [N-1:0] t);
        return ($countones(s) == 1) && (s == OWN) && (t != '0) && ((t & s) == '0);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int b = 0; b < 2; b++) begin
                if (!rst_n) begin
                    m_q[b].delete();
                    m_drop[b] = 0;
                    m_ov[b] = 1'b0;
                    m_pkt[b] = '0;
                    m_tx[b] = 1'b0;
                    model_ok = 1'b1;
                end else begin : upd
                    int sz;
                    bit rdy, pop, push, drop;
                    sz = m_q[b].size();
                    rdy = (b == 0) ? (sz != D) : 1'b1;
                    pop = grant && (sz > 0);
                    push = valid_in && rdy && legal(src, tgt) && (sz < D);
                    drop = valid_in && rdy && !push;
                    m_tx[b] = m_ov[b] && ready_out;
                    if (iv && (!m_ov[b] || ready_out)) begin
                        m_ov[b] = 1'b1;
                        m_pkt[b] = idata;
                    end else if (ready_out) begin
                        m_ov[b] = 1'b0;
                    end
                    if (pop) void'(m_q[b].pop_front());
                    if (push) m_q[b].push_back({src, tgt, data});
                    if (drop && m_drop[b] < 32'hFFFF) m_drop[b]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                for (int b = 0; b < 2; b++) begin : cmp
                    int sz;
                    string p;
                    logic [PKT_W-1:0] head;
                    sz = m_q[b].size();
                    p = (b == 0) ? "bp" : "dr";
                    head = (sz != 0) ? m_q[b][0] : '0;
                    chk({p, " ready_in"}, 32'(o_ready_in[b]),
                        (b == 0) ? 32'(sz != D) : 32'd1);
                    chk({p, " request"}, 32'(o_request[b]), 32'(sz != 0));
                    chk({p, " request_data"}, 32'(o_req_data[b]), 32'(head));
                    chk({p, " request_target"}, 32'(o_req_tgt[b]), 32'(head[DW +: N]));
                    chk({p, " internal_ready"}, 32'(o_iready[b]), 32'(!m_ov[b] || ready_out));
                    chk({p, " valid_out"}, 32'(o_valid_out[b]), 32'(m_ov[b]));
                    chk({p, " out_pkt"}, 32'(o_out_pkt[b]), 32'(m_pkt[b]));
                    chk({p, " tx_done"}, 32'(o_tx_done[b]), 32'(m_tx[b]));
                    chk({p, " fifo_count"}, 32'(o_count[b]), 32'(sz));
                    chk({p, " drop_count"}, 32'(o_drop[b]), m_drop[b]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] s, input logic [N-1:0] t, input logic [DW-1:0] d);
        valid_in = 1'b1;
        src = s;
        tgt = t;
        data = d;
    endtask

    int n_vo, n_tx;

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 2; b++) begin
            chk("rst ready_in", 32'(o_ready_in[b]), 1);
            chk("rst internal_ready", 32'(o_iready[b]), 1);
            chk("rst fifo_count", 32'(o_count[b]), 0);
            chk("rst valid_out", 32'(o_valid_out[b]), 0);
        end

        // Single legal packet through to the arbiter
        send(4'b0001, 4'b0100, 8'hA5);
        tick();
        valid_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk("t1 request", 32'(o_request[b]), 1);
            chk("t1 request_target", 32'(o_req_tgt[b]), 32'h4);
            chk("t1 request_data", 32'(o_req_data[b]), 32'h14A5);
        end
        grant = 1'b1;
        tick();
        grant = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk("t1 request after grant", 32'(o_request[b]), 0);
            chk("t1 count after grant", 32'(o_count[b]), 0);
        end

        // Illegal packets
        send(4'b0001, 4'b0001, 8'h01); tick();
        send(4'b0011, 4'b0100, 8'h02); tick();
        send(4'b0001, 4'b0000, 8'h03); tick();
        valid_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk("t2 drop_count", 32'(o_drop[b]), 3);
            chk("t2 request", 32'(o_request[b]), 0);
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Fill to full, then push a fifth while full
        for (int i = 0; i < 4; i++) begin
            send(4'b0001, 4'b1000, 8'(8'h10 + i));
            tick();
        end
        chk("t3 bp ready_in full", 32'(o_ready_in[0]), 0);
        chk("t4 dr ready_in full", 32'(o_ready_in[1]), 1);
        send(4'b0001, 4'b1000, 8'h14);
        tick();
        chk("t3 bp drop held", 32'(o_drop[0]), 0);
        chk("t4 dr drop fifth", 32'(o_drop[1]), 1);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("t3 bp count after grant", 32'(o_count[0]), 3);
        chk("t3 bp ready_in after grant", 32'(o_ready_in[0]), 1);
        chk("t4 dr count full+grant", 32'(o_count[1]), 3);
        chk("t4 dr drop full+grant", 32'(o_drop[1]), 2);
        tick();
        valid_in = 1'b0;
        chk("t3 bp fifth accepted", 32'(o_count[0]), 4);
        for (int i = 1; i <= 4; i++) begin
            for (int b = 0; b < 2; b++) begin
                chk("t3 fifo order", 32'(o_req_data[b]), 32'h1800 + 32'(8'h10 + i));
            end
            grant = 1'b1;
            tick();
        end
        grant = 1'b0;

        // Egress stall then back-to-back
        iv = 1'b1;
        idata = 16'h2139;
        ready_out = 1'b0;
        tick();
        iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 2; b++) begin
                chk("t5 valid_out held", 32'(o_valid_out[b]), 1);
                chk("t5 out held", 32'(o_out_pkt[b]), 32'h2139);
                chk("t5 internal_ready", 32'(o_iready[b]), 0);
            end
            tick();
        end
        ready_out = 1'b1;
        tick();
        chk("t5 tx_done pulse", 32'(o_tx_done[0]), 1);
        chk("t5 valid_out drop", 32'(o_valid_out[0]), 0);
        tick();
        chk("t5 tx_done single", 32'(o_tx_done[0]), 0);
        n_vo = 0;
        n_tx = 0;
        iv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) idata = 16'h3100 + 16'(i);
            else iv = 1'b0;
            tick();
            n_vo += int'(o_valid_out[1]);
            n_tx += int'(o_tx_done[1]);
        end
        chk("t5 b2b valid cycles", 32'(n_vo), 4);
        chk("t5 b2b tx_done pulses", 32'(n_tx), 4);

        // Reset with queued and in-flight packets
        for (int i = 0; i < 3; i++) begin
            send(4'b0001, 4'b0010, 8'(8'h40 + i));
            tick();
        end
        valid_in = 1'b0;
        ready_out = 1'b0;
        iv = 1'b1;
        idata = 16'h1277;
        tick();
        iv = 1'b0;
        chk("t6 pre count", 32'(o_count[0]), 3);
        chk("t6 pre valid_out", 32'(o_valid_out[0]), 1);
        ready_out = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 2; b++) begin
            chk("t6 count", 32'(o_count[b]), 0);
            chk("t6 valid_out", 32'(o_valid_out[b]), 0);
            chk("t6 drop", 32'(o_drop[b]), 0);
            chk("t6 no tx_done", 32'(o_tx_done[b]), 0);
        end
        send(4'b0001, 4'b0010, 8'h55);
        tick();
        valid_in = 1'b0;
        chk("t6 resume request", 32'(o_request[0]), 1);
        chk("t6 resume data", 32'(o_req_data[0]), 32'h1255);

        // Random traffic; low grant rate first to exercise full conditions
        for (int i = 0; i < 2400; i++) begin
            int gpct;
            gpct = (i < 1200) ? 15 : 50;
            rst_n = ($urandom_range(0, 299) != 0);
            valid_in = ($urandom_range(0, 99) < 65);
            src = ($urandom_range(0, 3) != 0) ? OWN : N'($urandom);
            tgt = ($urandom_range(0, 3) != 0) ? N'($urandom_range(1, 7) << 1) : N'($urandom);
            data = DW'($urandom);
            grant = ($urandom_range(0, 99) < gpct);
            iv = ($urandom_range(0, 1) == 1);
            idata = PKT_W'($urandom);
            ready_out = ($urandom_range(0, 99) < 60);
            tick();
        end
        rst_n = 1'b1;
        valid_in = 1'b0;
        grant = 1'b0;
        iv = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/switch_port_gen2.md
Name: switch_port_gen2

Overview:
Parametrised second-generation switch port.
- Ingress: accepts packets from the link, checks legality and buffers them in a FIFO. Ingress is single-cycle: there is no capture state.
- Arbitration: presents the FIFO head to the switch arbiter as request / request_target / request_data and pops on grant.
- Egress: an output register with a valid/ready handshake drives packets onto the link.
- New over the previous generation: port count and data width are generic, full-FIFO behaviour is selectable (backpressure or drop), the link egress has real flow control, and the block exposes occupancy and drop counters.

Parameters:
N_PORTS, 4, width of the one-hot source/target fields (one bit per switch port)
DATA_W, 8, payload width
FIFO_DEPTH, 16, ingress FIFO entries; must be a power of two, ≥2
PORT_ID, 0, index of this port (0..N_PORTS-1)
BACKPRESSURE, 1, 1 = deassert ready_in when full; 0 = ready_in tied high, arrivals while full are dropped and counted
Derived localparams: PKT_W = 2*N_PORTS+DATA_W; AW = $clog2(FIFO_DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
valid_in  in  1  link ingress valid
ready_in  out  1  link ingress ready
source_in  in  N_PORTS  one-hot source
target_in  in  N_PORTS  target bitmap
data_in  in  DATA_W  payload
valid_out  out  1  link egress valid
ready_out  in  1  link egress ready
source_out  out  N_PORTS  egress source
target_out  out  N_PORTS  egress target
data_out  out  DATA_W  egress payload
tx_done  out  1  one-cycle pulse after each completed egress handshake
request  out  1  FIFO non-empty
request_target  out  N_PORTS  head target, 0 when empty
request_data  out  PKT_W  head packet {src,tgt,data}, 0 when empty
grant  in  1  arbiter pops head this cycle
internal_valid  in  1  packet from switch fabric
internal_ready  out  1  egress can take internal_data this cycle
internal_data  in  PKT_W  {src,tgt,data}
fifo_count  out  AW+1  current occupancy
drop_count  out  16  saturating count of dropped packets

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Clears FIFO pointers, fifo_count, drop_count, valid_out, tx_done, source_out, target_out and data_out.
  - FIFO memory is not cleared.
  - Reset mid-operation flushes all queued and in-flight packets; no tx_done is produced for a flushed egress packet.
  - ready_in=1 and internal_ready=1 in the first cycle after reset.
- Legality: a packet is illegal if any of these holds:
  - source_in is not one-hot;
  - source_in != (1<<PORT_ID);
  - target_in == 0;
  - (target_in & source_in) != 0.
- ready_in:
  - BACKPRESSURE=1: ready_in = (fifo_count != FIFO_DEPTH).
  - BACKPRESSURE=0: ready_in = 1.
- Ingress, evaluated each cycle with valid_in && ready_in:
  - Legal and FIFO not full: write {source_in,target_in,data_in} at wr_ptr; the entry is visible at the head on the next cycle.
  - Illegal: discard, drop_count+1.
  - Legal but FIFO full (BACKPRESSURE=0 only): discard, drop_count+1. This holds even if grant pops in the same cycle; there is no same-cycle bypass.
- drop_count saturates at 16'hFFFF.
- Ingress latency: accept edge → request high one cycle later.
- Arbiter side (combinational):
  - request = (fifo_count != 0);
  - request_data = head entry;
  - request_target = head target field.
- Pop:
  - grant && request: rd_ptr+1 (wraps mod FIFO_DEPTH).
  - grant while empty: ignored, no pointer or count change.
- fifo_count: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop. It never exceeds FIFO_DEPTH and never underflows.
- Egress register:
  - internal_ready = !valid_out || ready_out.
  - internal_valid && internal_ready: at the next edge, valid_out=1 and {source_out,target_out,data_out}=internal_data.
  - valid_out && !ready_out: valid_out and data held stable.
  - valid_out && ready_out && !internal_valid: valid_out←0.
  - Back-to-back transfers give full throughput: one packet per cycle while ready_out=1.
- tx_done = registered (valid_out && ready_out): a 1-cycle pulse in the cycle after each handshake. Consecutive handshakes give consecutive pulses.
- Ingress and egress paths are independent; no ordering between them.

Test Plan:
1. PORT_ID=0, send src=0001 tgt=0100 data=A5 → request high one cycle later; request_target=0100; request_data=16'h14A5; grant → request low, fifo_count=0.
2. Send src=0001 tgt=0001, then src=0011 tgt=0100, then src=0001 tgt=0000 → none enqueued; drop_count=3; request stays low.
3. FIFO_DEPTH=4, BACKPRESSURE=1, 5 legal packets, no grant → ready_in low after the 4th; 5th held by producer; one grant → ready_in=1 next cycle; 5th accepted; FIFO order preserved.
4. BACKPRESSURE=0, same stimulus → 5th dropped, drop_count=1. A 6th arrives full with simultaneous grant → also dropped, fifo_count=3.
5. internal_valid with data 16'h2139 while ready_out=0 for 3 cycles → valid_out held, outputs stable, internal_ready=0; ready_out=1 → handshake, tx_done pulse next cycle. Then 4 back-to-back packets with ready_out=1 → 4 consecutive valid_out cycles and 4 tx_done pulses.
6. rst_n low for one edge with 3 queued packets and valid_out=1 → fifo_count=0, valid_out=0, drop_count=0, no tx_done; normal traffic resumes the next cycle.
